// File: rtl/sand_pkg.sv
// rtl/sand_pkg.sv - shared types for the sandpile sweep controller, tile RAM and toppling kernel
package sand_pkg;

   localparam int TILE_ADDR_W   = 10;
   localparam int DEF_CELL_W    = 3;
   localparam int DEF_TILE_SIZE = 16;

   typedef logic [DEF_TILE_SIZE-1:0][DEF_CELL_W-1:0] tile_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_RD_REQ,
      S_RD_CAP,
      S_K_SEND,
      S_K_WAIT,
      S_WR,
      S_FLIP
   } sweep_state_e;

endpackage

// File: rtl/sand_sweep_ctrl.sv
// rtl/sand_sweep_ctrl.sv - tile sweep sequencer between double-buffered tile RAM and toppling kernel
// Optional SAND_AUTORUN_EN: keep sweeping until a sweep reports no change.
module sand_sweep_ctrl
   import sand_pkg::*;
#(
   parameter int ROWS       = 128,
   parameter int COLS       = 128,
   parameter int ROWS_TILE  = 4,
   parameter int COLS_TILE  = 4,
   parameter int CELL_WIDTH = 3,
   parameter int TILE_SIZE  = ROWS_TILE*COLS_TILE,
   parameter int TILES      = (ROWS/ROWS_TILE)*(COLS/COLS_TILE)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             clear,
   output logic                             busy,
   output logic                             sweep_done,
   output logic                             stable,
   output logic [TILE_ADDR_W-1:0]           tile_addr,
   output logic                             read_tile,
   output logic                             write_tile,
   output logic                             reset_tile,
   output logic                             read_ram_a,
   input  logic [CELL_WIDTH*TILE_SIZE-1:0]  ram_rdata,
   output logic [CELL_WIDTH*TILE_SIZE-1:0]  ram_wdata,
   output logic                             k_valid,
   input  logic                             k_ready,
   output logic [CELL_WIDTH*TILE_SIZE-1:0]  k_data,
   output logic [TILE_ADDR_W-1:0]           k_addr,
   input  logic                             r_valid,
   output logic                             r_ready,
   input  logic [CELL_WIDTH*TILE_SIZE-1:0]  r_data,
   input  logic                             r_changed
);

   localparam int TW = CELL_WIDTH*TILE_SIZE;
   localparam logic [TILE_ADDR_W-1:0] LAST_ADDR = TILE_ADDR_W'(TILES-1);

   sweep_state_e           state_q, state_d;
   logic [TILE_ADDR_W-1:0] addr_q, addr_d;
   logic [TW-1:0]          tile_q, tile_d;
   logic                   pass_q, pass_d;
   logic                   changed_q, changed_d;
   logic                   rra_q, rra_d;
   logic                   stable_q, stable_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         tile_q    <= '0;
         pass_q    <= 1'b0;
         changed_q <= 1'b0;
         rra_q     <= 1'b1;
         stable_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         tile_q    <= tile_d;
         pass_q    <= pass_d;
         changed_q <= changed_d;
         rra_q     <= rra_d;
         stable_q  <= stable_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      tile_d    = tile_q;
      pass_d    = pass_q;
      changed_d = changed_q;
      rra_d     = rra_q;
      stable_d  = stable_q;
      case (state_q)
         S_IDLE: begin
            if (clear) begin
               state_d = S_CLR;
               addr_d  = '0;
               pass_d  = 1'b0;
            end else if (start) begin
               state_d   = S_RD_REQ;
               addr_d    = '0;
               changed_d = 1'b0;
            end
         end
         // Each pass clears the bank currently on the write side; two passes cover both.
         S_CLR: begin
            if (addr_q == LAST_ADDR) begin
               addr_d = '0;
               rra_d  = ~rra_q;
               if (!pass_q) pass_d  = 1'b1;
               else         state_d = S_IDLE;
            end else begin
               addr_d = addr_q + TILE_ADDR_W'(1);
            end
         end
         S_RD_REQ: state_d = S_RD_CAP;
         S_RD_CAP: begin
            tile_d  = ram_rdata;
            state_d = S_K_SEND;
         end
         S_K_SEND: if (k_ready) state_d = S_K_WAIT;
         S_K_WAIT: begin
            if (r_valid) begin
               tile_d    = r_data;
               changed_d = changed_q | r_changed;
               state_d   = S_WR;
            end
         end
         S_WR: begin
            if (addr_q == LAST_ADDR) begin
               state_d = S_FLIP;
            end else begin
               addr_d  = addr_q + TILE_ADDR_W'(1);
               state_d = S_RD_REQ;
            end
         end
         S_FLIP: begin
            rra_d    = ~rra_q;
            stable_d = ~changed_q;
            addr_d   = '0;
`ifdef SAND_AUTORUN_EN
            if (changed_q) begin
               state_d   = S_RD_REQ;
               changed_d = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign read_tile  = (state_q == S_RD_REQ) || (state_q == S_RD_CAP);
   assign write_tile = (state_q == S_WR);
   assign reset_tile = (state_q == S_CLR);
   assign tile_addr  = (read_tile || write_tile || reset_tile) ? addr_q : '0;
   assign read_ram_a = rra_q;
   assign ram_wdata  = tile_q;
   assign k_valid    = (state_q == S_K_SEND);
   assign k_data     = tile_q;
   assign k_addr     = addr_q;
   assign r_ready    = (state_q == S_K_WAIT);
   assign busy       = (state_q != S_IDLE);
   assign sweep_done = (state_q == S_FLIP);
   // Fresh verdict is visible during the sweep_done cycle itself, then held.
   assign stable     = (state_q == S_FLIP) ? ~changed_q : stable_q;

endmodule

// File: tb/tb_sand_sweep_ctrl.sv
// tb/tb_sand_sweep_ctrl.sv - directed self-checking bench for sand_sweep_ctrl on a 16-tile grid
module tb_sand_sweep_ctrl;

   localparam int TW = 48;
   localparam int NT = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          clear = 1'b0;
   logic          busy, sweep_done, stable;
   logic [9:0]    tile_addr, k_addr;
   logic          read_tile, write_tile, reset_tile, read_ram_a;
   logic [TW-1:0] ram_rdata, ram_wdata, k_data, r_data;
   logic          k_valid, k_ready, r_valid, r_ready, r_changed;

   int checks = 0;
   int failures = 0;

   logic          k_ready_en = 1'b1;
   logic [TW-1:0] kmask = '0;
   logic          chg_en = 1'b0;
   logic [9:0]    chg_addr = '0;
   logic          fill_req = 1'b0;
   logic          exp_rra;

   logic          have;
   logic [TW-1:0] kbuf;
   logic [9:0]    kaddr;
   logic [TW-1:0] bank_a [NT];
   logic [TW-1:0] bank_b [NT];
   int            wr_log [$];
   int            rd_n;

   sand_sweep_ctrl #(.ROWS(16), .COLS(16), .ROWS_TILE(4), .COLS_TILE(4), .CELL_WIDTH(3)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .busy(busy),
      .sweep_done(sweep_done), .stable(stable), .tile_addr(tile_addr),
      .read_tile(read_tile), .write_tile(write_tile), .reset_tile(reset_tile),
      .read_ram_a(read_ram_a), .ram_rdata(ram_rdata), .ram_wdata(ram_wdata),
      .k_valid(k_valid), .k_ready(k_ready), .k_data(k_data), .k_addr(k_addr),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_changed(r_changed)
   );

   always #5 clk = ~clk;

   function automatic logic [TW-1:0] pat(input int i);
      return {12'(i*37+5), 12'(i*91+3), 12'(~i), 12'(i*7+1)};
   endfunction

   // Kernel model: single-slot buffer, result offered the cycle after acceptance.
   assign k_ready   = k_ready_en & ~have;
   assign r_valid   = have;
   assign r_data    = kbuf;
   assign r_changed = have & chg_en & (kaddr == chg_addr);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         have <= 1'b0;
      end else if (k_valid && k_ready) begin
         have  <= 1'b1;
         kbuf  <= k_data ^ kmask;
         kaddr <= k_addr;
      end else if (have && r_ready) begin
         have <= 1'b0;
      end
   end

   // Two-bank tile RAM with one-cycle read latency.
   always @(posedge clk) begin
      if (fill_req) for (int i = 0; i < NT; i++) bank_a[i] <= pat(i);
      if (read_tile) ram_rdata <= read_ram_a ? bank_a[tile_addr[3:0]] : bank_b[tile_addr[3:0]];
      if (write_tile) begin
         if (read_ram_a) bank_b[tile_addr[3:0]] <= ram_wdata;
         else            bank_a[tile_addr[3:0]] <= ram_wdata;
      end
      if (reset_tile) begin
         if (read_ram_a) bank_b[tile_addr[3:0]] <= '0;
         else            bank_a[tile_addr[3:0]] <= '0;
      end
   end

   task automatic pulse(input logic s, input logic c);
      @(negedge clk);
      start = s;
      clear = c;
      @(negedge clk);
      start = 1'b0;
      clear = 1'b0;
   endtask

   task automatic wait_done(input int bound, output int cyc);
      logic prev_rd = 1'b0;
      wr_log.delete();
      rd_n = 0;
      cyc = 1;
      while (!sweep_done && cyc < bound) begin
         if (write_tile) wr_log.push_back(int'(tile_addr));
         if (read_tile && !prev_rd) rd_n++;
         prev_rd = read_tile;
         @(negedge clk);
         cyc++;
      end
      if (!sweep_done) cyc = -1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (read_ram_a !== 1'b1) begin failures++; $display("FAIL reset_rra got=%b exp=1", read_ram_a); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if ({read_tile, write_tile, reset_tile, k_valid, r_ready} !== 5'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=0", {read_tile, write_tile, reset_tile, k_valid, r_ready}); end
      checks++; if ({sweep_done, stable, tile_addr, k_addr} !== 22'b0) begin failures++; $display("FAIL reset_misc got=%h exp=0", {sweep_done, stable, tile_addr, k_addr}); end
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if ({busy, read_ram_a, k_data} !== {2'b01, 48'b0}) begin failures++; $display("FAIL reset_release got=%h exp=%h", {busy, read_ram_a, k_data}, {2'b01, 48'b0}); end
      exp_rra = 1'b1;
   endtask

   task automatic test_clear(input string tag, input logic with_start);
      int bad = 0;
      int rd = 0;
      pulse(with_start, 1'b1);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL %s_busy_rise got=%b exp=1", tag, busy); end
      for (int i = 0; i < 2*NT; i++) begin
         if (reset_tile !== 1'b1 || tile_addr !== 10'(i % NT)) bad++;
         if (read_tile) rd++;
         @(negedge clk);
      end
      checks++; if (bad !== 0) begin failures++; $display("FAIL %s_seq got=%0d bad_cycles exp=0", tag, bad); end
      checks++; if (rd !== 0) begin failures++; $display("FAIL %s_no_read got=%0d exp=0", tag, rd); end
      checks++; if ({busy, reset_tile, tile_addr} !== 12'b0) begin failures++; $display("FAIL %s_end got=%h exp=0", tag, {busy, reset_tile, tile_addr}); end
      checks++; if (read_ram_a !== exp_rra) begin failures++; $display("FAIL %s_rra got=%b exp=%b", tag, read_ram_a, exp_rra); end
      bad = 0;
      for (int i = 0; i < NT; i++) if (bank_a[i] !== '0 || bank_b[i] !== '0) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL %s_banks got=%0d nonzero exp=0", tag, bad); end
   endtask

   task automatic test_sweep();
      int cyc;
      int bad = 0;
      @(negedge clk);
      fill_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
      kmask = '0;
      pulse(1'b1, 1'b0);
      wait_done(300, cyc);
      checks++; if (cyc !== 81) begin failures++; $display("FAIL sweep_cycles got=%0d exp=81", cyc); end
      checks++; if (stable !== 1'b1) begin failures++; $display("FAIL sweep_stable got=%b exp=1", stable); end
      checks++; if (rd_n !== NT) begin failures++; $display("FAIL sweep_reads got=%0d exp=%0d", rd_n, NT); end
      checks++; if (wr_log.size() !== NT) begin failures++; $display("FAIL sweep_writes got=%0d exp=%0d", wr_log.size(), NT); end
      foreach (wr_log[i]) if (wr_log[i] !== i) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL sweep_order got=%0d bad exp=0", bad); end
      @(negedge clk);
      exp_rra = 1'b0;
      checks++; if ({read_ram_a, busy, sweep_done, stable} !== 4'b0001) begin failures++; $display("FAIL sweep_after got=%b exp=0001", {read_ram_a, busy, sweep_done, stable}); end
      bad = 0;
      for (int i = 0; i < NT; i++) if (bank_b[i] !== pat(i)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL sweep_bank_b got=%0d bad exp=0", bad); end
   endtask

   task automatic test_backpressure();
      int cyc = 1;
      int stall = 7;
      int bad = 0;
      kmask = 48'hA5A5_5A5A_F0F0;
      pulse(1'b1, 1'b0);
      while (!sweep_done && cyc < 300) begin
         if (k_valid && k_addr == 10'd3 && stall > 0) begin
            k_ready_en = 1'b0;
            stall--;
            checks++;
            if (k_data !== pat(3) || write_tile !== 1'b0) begin
               failures++;
               $display("FAIL bp_hold got=%h/%b exp=%h/0", k_data, write_tile, pat(3));
            end
         end else begin
            k_ready_en = 1'b1;
         end
         @(negedge clk);
         cyc++;
      end
      k_ready_en = 1'b1;
      checks++; if (cyc !== 88) begin failures++; $display("FAIL bp_cycles got=%0d exp=88", cyc); end
      checks++; if (stall !== 0) begin failures++; $display("FAIL bp_stall_seen got=%0d exp=0", stall); end
      @(negedge clk);
      exp_rra = 1'b1;
      checks++; if (read_ram_a !== exp_rra) begin failures++; $display("FAIL bp_rra got=%b exp=%b", read_ram_a, exp_rra); end
      for (int i = 0; i < NT; i++) if (bank_a[i] !== (pat(i) ^ kmask)) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL bp_bank_a got=%0d bad exp=0", bad); end
   endtask

   task automatic test_change();
      int cyc;
      kmask = '0;
      chg_en = 1'b1;
      chg_addr = 10'd15;
      pulse(1'b1, 1'b0);
      wait_done(300, cyc);
      checks++; if (cyc !== 81) begin failures++; $display("FAIL chg_cycles got=%0d exp=81", cyc); end
      checks++; if (stable !== 1'b0) begin failures++; $display("FAIL chg_stable got=%b exp=0", stable); end
      @(negedge clk);
      chg_en = 1'b0;
      exp_rra = 1'b0;
      checks++; if (read_ram_a !== exp_rra) begin failures++; $display("FAIL chg_rra got=%b exp=%b", read_ram_a, exp_rra); end
`ifdef SAND_AUTORUN_EN
      checks++; if ({busy, read_tile} !== 2'b11) begin failures++; $display("FAIL chg_autorun got=%b exp=11", {busy, read_tile}); end
      wait_done(300, cyc);
      checks++; if (cyc !== 81) begin failures++; $display("FAIL chg_rerun_cycles got=%0d exp=81", cyc); end
      checks++; if (stable !== 1'b1) begin failures++; $display("FAIL chg_rerun_stable got=%b exp=1", stable); end
      @(negedge clk);
      exp_rra = 1'b1;
      checks++; if ({busy, read_ram_a} !== {1'b0, exp_rra}) begin failures++; $display("FAIL chg_rerun_end got=%b exp=0%b", {busy, read_ram_a}, exp_rra); end
`else
      checks++; if ({busy, stable} !== 2'b00) begin failures++; $display("FAIL chg_idle got=%b exp=00", {busy, stable}); end
`endif
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      pulse(1'b1, 1'b0);
      while (!(write_tile && tile_addr == 10'd8) && cyc < 300) begin
         @(negedge clk);
         cyc++;
      end
      checks++; if (write_tile !== 1'b1) begin failures++; $display("FAIL rst_mid_reach got=%b exp=1", write_tile); end
      rst_n = 1'b0;
      #1;
      checks++; if ({busy, read_ram_a, read_tile, write_tile, reset_tile, k_valid, r_ready, sweep_done, stable} !== 9'b010000000) begin
         failures++; $display("FAIL rst_mid_ctrl got=%b exp=010000000", {busy, read_ram_a, read_tile, write_tile, reset_tile, k_valid, r_ready, sweep_done, stable});
      end
      checks++; if ({tile_addr, k_addr, k_data, ram_wdata} !== 116'b0) begin failures++; $display("FAIL rst_mid_data got=%h exp=0", {tile_addr, k_addr, k_data, ram_wdata}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_idle got=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_clear("clear", 1'b0);
      test_sweep();
      test_backpressure();
      test_change();
      test_clear("clr_start", 1'b1);
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
